// File: rtl/sparse_accum_stage_if.sv
// Bus bundle for sparse_accum_stage: fetch-stage input, weight RAM port and result handshake.
// The slave modport is the accumulator's view; master is the surrounding environment.
interface sparse_accum_stage_if;
  logic [31:0] nz;
  logic [31:0] nzposition;
  logic        valid;
  logic        layer_done;
  logic        next_stage_rdy;
  logic [15:0] wt_addr;
  logic [31:0] wt_rddata;
  logic [31:0] out_data;
  logic [15:0] out_row;
  logic        out_valid;
  logic        out_ready;
  logic        acc_done;

  modport master (
    output nz, nzposition, valid, layer_done, wt_rddata, out_ready,
    input  next_stage_rdy, wt_addr, out_data, out_row, out_valid, acc_done
  );

  modport slave (
    input  nz, nzposition, valid, layer_done, wt_rddata, out_ready,
    output next_stage_rdy, wt_addr, out_data, out_row, out_valid, acc_done
  );
endinterface

// File: rtl/sparse_accum_stage.sv
// sparse_accum_stage: buffers sparse nonzeros, multiplies them by fetched weights and emits per-row sums.
// Define SPARSE_ACC_SAT_EN for saturating accumulation; the default build wraps modulo 2^32.
module sparse_accum_stage (
  input  logic                clk,
  input  logic                reset,
  sparse_accum_stage_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [31:0] SENTINEL = 32'hFFFF_FFFF;
  localparam logic [2:0]  DEPTH    = 3'd4;

  state_t state, state_next;

  logic [63:0] fifo_mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count, count_next;
  logic [63:0] head;
  logic        head_sentinel;
  logic        push, pop;

  logic        mul_pending;
  logic [31:0] mul_nz;
  logic [15:0] mul_row;
  logic [31:0] prod_low;

  logic        prod_valid;
  logic [31:0] prod;
  logic [15:0] prod_row;
  logic        prod_consume;

  logic [31:0] acc, acc_next, acc_sum, wrap_sum;
  logic [15:0] cur_row, cur_row_next;
  logic        sentinel_seen, flush_ready;

  logic        out_valid_q, out_valid_next, out_free, load_out;
  logic [31:0] out_data_q;
  logic [15:0] out_row_q;
  logic        rdy_q, acc_done_q;
  logic        unused_layer_done;

  assign unused_layer_done = bus.layer_done;

  assign head          = fifo_mem[rd_ptr];
  assign head_sentinel = (head[31:0] == SENTINEL);
  assign push          = bus.valid && (count != DEPTH);
  // Only one product may be in flight: weight data is valid for a single cycle.
  assign pop           = (count != 3'd0) && !mul_pending && (!prod_valid || prod_consume)
                         && (state != DONE) && !sentinel_seen;
  assign bus.wt_addr   = (pop && !head_sentinel) ? head[15:0] : 16'd0;

  // Low 32 bits of a product are identical for signed and unsigned operands.
  assign prod_low = mul_nz * bus.wt_rddata;
  assign wrap_sum = acc + prod;

`ifdef SPARSE_ACC_SAT_EN
  always_comb begin
    acc_sum = wrap_sum;
    if ((acc[31] == prod[31]) && (wrap_sum[31] != acc[31]))
      acc_sum = acc[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  end
`else
  assign acc_sum = wrap_sum;
`endif

  assign out_free       = !out_valid_q || bus.out_ready;
  assign flush_ready    = sentinel_seen && !mul_pending && !prod_valid;
  assign out_valid_next = load_out || (out_valid_q && !bus.out_ready);

  always_comb begin
    state_next   = state;
    acc_next     = acc;
    cur_row_next = cur_row;
    prod_consume = 1'b0;
    load_out     = 1'b0;
    case (state)
      IDLE: begin
        if (prod_valid) begin
          prod_consume = 1'b1;
          acc_next     = prod;
          cur_row_next = prod_row;
          state_next   = ACCUM;
        end else if (flush_ready) begin
          state_next = DONE;
        end
      end
      ACCUM: begin
        if (prod_valid) begin
          if (prod_row == cur_row) begin
            prod_consume = 1'b1;
            acc_next     = acc_sum;
          end else if (out_free) begin
            prod_consume = 1'b1;
            load_out     = 1'b1;
            acc_next     = prod;
            cur_row_next = prod_row;
          end
        end else if (flush_ready && out_free) begin
          load_out   = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 3'd1;
    else if (pop && !push)
      count_next = count - 3'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {bus.nz, bus.nzposition};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
      rdy_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count_next;
      rdy_q <= (count_next <= 3'd2) && (state_next != DONE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_pending   <= 1'b0;
      mul_nz        <= 32'd0;
      mul_row       <= 16'd0;
      prod_valid    <= 1'b0;
      prod          <= 32'd0;
      prod_row      <= 16'd0;
      acc           <= 32'd0;
      cur_row       <= 16'd0;
      sentinel_seen <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= 32'd0;
      out_row_q     <= 16'd0;
      acc_done_q    <= 1'b0;
    end else begin
      mul_pending <= pop && !head_sentinel;
      if (pop) begin
        mul_nz  <= head[63:32];
        mul_row <= head[31:16];
      end
      if (pop && head_sentinel) sentinel_seen <= 1'b1;

      if (mul_pending) begin
        prod_valid <= 1'b1;
        prod       <= prod_low;
        prod_row   <= mul_row;
      end else if (prod_consume) begin
        prod_valid <= 1'b0;
      end

      acc     <= acc_next;
      cur_row <= cur_row_next;

      if (load_out) begin
        out_data_q <= acc;
        out_row_q  <= cur_row;
      end
      out_valid_q <= out_valid_next;
      acc_done_q  <= acc_done_q || ((state_next == DONE) && !out_valid_next);
    end
  end

  assign bus.next_stage_rdy = rdy_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_data       = out_data_q;
  assign bus.out_row        = out_row_q;
  assign bus.acc_done       = acc_done_q;

endmodule

// File: tb/tb_sparse_accum_stage.sv
// Testbench for sparse_accum_stage: directed and randomized layers checked against a row-sum model.
// Honours SPARSE_ACC_SAT_EN the same way as the design.
module tb_sparse_accum_stage;

  logic clk = 1'b0;
  logic reset;

  sparse_accum_stage_if bus ();

  sparse_accum_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] wt_mem [256];
  logic [31:0] stim_nz[$], stim_pos[$], exp_data[$], got_data[$];
  logic [15:0] exp_row[$], got_row[$];

  int compare_count = 0;
  int fail_count    = 0;
  int stall_cycles  = 0;
  bit random_ready  = 1'b0;
  bit hold_pending  = 1'b0;
  int hold_errors   = 0;
  bit saw_valid     = 1'b0;
  bit saw_rdy_low   = 1'b0;
  logic [31:0] held_data;
  logic [15:0] held_row;

  // Weight RAM: one-cycle read latency.
  always @(posedge clk) bus.wt_rddata <= wt_mem[bus.wt_addr[7:0]];

  always @(negedge clk) begin
    if (stall_cycles > 0) begin
      bus.out_ready = 1'b0;
      stall_cycles--;
    end else if (random_ready) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end else begin
      bus.out_ready = 1'b1;
    end
  end

  // Sample shortly before the next rising edge, after all drivers have settled.
  always @(negedge clk) begin
    #2;
    if (reset) begin
      if (bus.out_valid) saw_valid = 1'b1;
      if (!bus.next_stage_rdy) saw_rdy_low = 1'b1;
      if (hold_pending && (!bus.out_valid || bus.out_data !== held_data || bus.out_row !== held_row))
        hold_errors++;
      if (bus.out_valid && bus.out_ready) begin
        got_data.push_back(bus.out_data);
        got_row.push_back(bus.out_row);
      end
      hold_pending = bus.out_valid && !bus.out_ready;
      held_data    = bus.out_data;
      held_row     = bus.out_row;
    end else begin
      hold_pending = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compare_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic clearStim();
    stim_nz.delete();
    stim_pos.delete();
  endtask

  task automatic addEntry(input logic [31:0] nz, input logic [15:0] row, input logic [15:0] col);
    stim_nz.push_back(nz);
    stim_pos.push_back({row, col});
  endtask

  task automatic addSentinel();
    stim_nz.push_back(32'd0);
    stim_pos.push_back(32'hFFFF_FFFF);
  endtask

  task automatic genLayer(input int n);
    logic [15:0] row;
    clearStim();
    row = 16'($urandom_range(0, 3));
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) == 0) row = 16'($urandom_range(0, 3));
      addEntry($urandom, row, 16'($urandom_range(0, 255)));
    end
    addSentinel();
  endtask

  function automatic logic [31:0] addModel(input logic [31:0] a, input logic [31:0] b);
    longint s;
    logic [63:0] sv;
    s  = longint'($signed(a)) + longint'($signed(b));
`ifdef SPARSE_ACC_SAT_EN
    if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
    sv = s;
    return sv[31:0];
  endfunction

  // Reference: products grouped into contiguous runs of equal row, one sum per run.
  task automatic buildExpected();
    logic [31:0] pos, accum, p;
    logic [63:0] p64;
    logic [15:0] row;
    bit open;
    open  = 1'b0;
    accum = 32'd0;
    row   = 16'd0;
    exp_data.delete();
    exp_row.delete();
    for (int i = 0; i < stim_pos.size(); i++) begin
      pos = stim_pos[i];
      if (pos == 32'hFFFF_FFFF) break;
      p64 = longint'($signed(stim_nz[i])) * longint'($signed(wt_mem[pos[7:0]]));
      p   = p64[31:0];
      if (open && pos[31:16] == row) begin
        accum = addModel(accum, p);
      end else begin
        if (open) begin
          exp_data.push_back(accum);
          exp_row.push_back(row);
        end
        open  = 1'b1;
        row   = pos[31:16];
        accum = p;
      end
    end
    if (open) begin
      exp_data.push_back(accum);
      exp_row.push_back(row);
    end
  endtask

  // The fetch stage answers a ready with one cycle of latency.
  task automatic applyStimulus();
    int idx = 0;
    int cycles = 0;
    bit prev_rdy = 1'b0;
    while (idx < stim_pos.size() && cycles < 5000) begin
      @(negedge clk);
      cycles++;
      if (prev_rdy) begin
        bus.valid      = 1'b1;
        bus.nz         = stim_nz[idx];
        bus.nzposition = stim_pos[idx];
        idx++;
      end else begin
        bus.valid = 1'b0;
      end
      prev_rdy = bus.next_stage_rdy;
    end
    @(negedge clk);
    bus.valid = 1'b0;
    checkOutput("feed_all_entries", idx, stim_pos.size());
  endtask

  task automatic waitDone(input string tag);
    int n = 0;
    while (!bus.acc_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_acc_done"}, {31'd0, bus.acc_done}, 32'd1);
  endtask

  function automatic logic [31:0] gotDataAt(input int i);
    return (i < got_data.size()) ? got_data[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] gotRowAt(input int i);
    return (i < got_row.size()) ? {16'd0, got_row[i]} : 32'hDEAD_BEEF;
  endfunction

  task automatic checkResults(input string tag);
    checkOutput({tag, "_count"}, got_data.size(), exp_data.size());
    for (int i = 0; i < exp_data.size(); i++) begin
      checkOutput($sformatf("%s_row%0d", tag, i), gotRowAt(i), {16'd0, exp_row[i]});
      checkOutput($sformatf("%s_data%0d", tag, i), gotDataAt(i), exp_data[i]);
    end
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    got_data.delete();
    got_row.delete();
    saw_valid   = 1'b0;
    hold_errors = 0;
  endtask

  initial begin
    logic [31:0] sat_expected;
    reset          = 1'b0;
    bus.valid      = 1'b0;
    bus.nz         = 32'd0;
    bus.nzposition = 32'd0;
    bus.layer_done = 1'b0;
    for (int i = 0; i < 256; i++) wt_mem[i] = $urandom;

    repeat (3) @(negedge clk);
    checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("rst_out_data", bus.out_data, 32'd0);
    checkOutput("rst_out_row", {16'd0, bus.out_row}, 32'd0);
    checkOutput("rst_wt_addr", {16'd0, bus.wt_addr}, 32'd0);
    checkOutput("rst_acc_done", {31'd0, bus.acc_done}, 32'd0);
    checkOutput("rst_rdy", {31'd0, bus.next_stage_rdy}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rdy_after_release", {31'd0, bus.next_stage_rdy}, 32'd1);

    $display("[TB] two nonzeros on row 0, weights 5 and 4");
    wt_mem[1] = 32'd5;
    wt_mem[2] = 32'd4;
    clearStim();
    addEntry(32'd2, 16'd0, 16'd1);
    addEntry(32'd3, 16'd0, 16'd2);
    addSentinel();
    applyStimulus();
    waitDone("basic");
    checkOutput("basic_count", got_data.size(), 32'd1);
    checkOutput("basic_row", gotRowAt(0), 32'd0);
    checkOutput("basic_data", gotDataAt(0), 32'd22);

    $display("[TB] rows 0,0,1 with products 1,2,7");
    pulseReset();
    wt_mem[10] = 32'd1;
    clearStim();
    addEntry(32'd1, 16'd0, 16'd10);
    addEntry(32'd2, 16'd0, 16'd10);
    addEntry(32'd7, 16'd1, 16'd10);
    addSentinel();
    applyStimulus();
    waitDone("rows");
    checkOutput("rows_count", got_data.size(), 32'd2);
    checkOutput("rows_row0", gotRowAt(0), 32'd0);
    checkOutput("rows_data0", gotDataAt(0), 32'd3);
    checkOutput("rows_row1", gotRowAt(1), 32'd1);
    checkOutput("rows_data1", gotDataAt(1), 32'd7);

    $display("[TB] signed overflow on accumulate");
    pulseReset();
    wt_mem[20] = 32'd1;
    clearStim();
    addEntry(32'h7FFF_FFFF, 16'd5, 16'd20);
    addEntry(32'd1, 16'd5, 16'd20);
    addSentinel();
`ifdef SPARSE_ACC_SAT_EN
    sat_expected = 32'h7FFF_FFFF;
`else
    sat_expected = 32'h8000_0000;
`endif
    applyStimulus();
    waitDone("ovf");
    checkOutput("ovf_count", got_data.size(), 32'd1);
    checkOutput("ovf_row", gotRowAt(0), 32'd5);
    checkOutput("ovf_data", gotDataAt(0), sat_expected);

    $display("[TB] sentinel as first entry");
    pulseReset();
    clearStim();
    addSentinel();
    applyStimulus();
    waitDone("empty");
    repeat (3) @(negedge clk);
    checkOutput("empty_no_valid", {31'd0, saw_valid}, 32'd0);
    checkOutput("empty_rdy", {31'd0, bus.next_stage_rdy}, 32'd0);

    $display("[TB] 20-cycle output stall during a continuous stream");
    pulseReset();
    clearStim();
    for (int i = 0; i < 24; i++) addEntry($urandom, 16'(i / 3), 16'($urandom_range(0, 255)));
    addSentinel();
    buildExpected();
    saw_rdy_low  = 1'b0;
    stall_cycles = 20;
    applyStimulus();
    waitDone("stall");
    checkResults("stall");
    checkOutput("stall_hold_stable", hold_errors, 32'd0);
    checkOutput("stall_rdy_dropped", {31'd0, saw_rdy_low}, 32'd1);

    $display("[TB] randomized layers with random back-pressure");
    random_ready = 1'b1;
    for (int l = 0; l < 3; l++) begin
      pulseReset();
      genLayer(20 + l * 8);
      buildExpected();
      applyStimulus();
      waitDone($sformatf("rand%0d", l));
      checkResults($sformatf("rand%0d", l));
      checkOutput($sformatf("rand%0d_hold", l), hold_errors, 32'd0);
    end
    random_ready = 1'b0;

    $display("[TB] reset pulse with entries in flight");
    pulseReset();
    clearStim();
    for (int i = 0; i < 3; i++) addEntry($urandom, 16'd7, 16'($urandom_range(0, 255)));
    applyStimulus();
    reset = 1'b0;
    #1;
    checkOutput("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("midrst_out_data", bus.out_data, 32'd0);
    checkOutput("midrst_out_row", {16'd0, bus.out_row}, 32'd0);
    checkOutput("midrst_wt_addr", {16'd0, bus.wt_addr}, 32'd0);
    checkOutput("midrst_acc_done", {31'd0, bus.acc_done}, 32'd0);
    checkOutput("midrst_rdy", {31'd0, bus.next_stage_rdy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_rdy_release", {31'd0, bus.next_stage_rdy}, 32'd1);
    repeat (5) @(negedge clk);
    checkOutput("midrst_no_output", got_data.size(), 32'd0);
    genLayer(12);
    buildExpected();
    applyStimulus();
    waitDone("fresh");
    checkResults("fresh");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
